// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Watches a multiplexed seven-segment display bus and rebuilds the digit
// values it shows. Each {segment, anode} sample must stay unchanged for
// STABLE_CYCLES registered samples before that digit is taken. Once every
// digit position has been seen, the frame is held for the consumer.
//
// Optional feature: define SEG_DECODE_HEX_EN to also decode A, b, C, d, E, F
// as values 10..15. Without it those patterns count as invalid.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   seg_in       segment pattern {g,f,e,d,c,b,a}, active-low
//   an_in        digit enables, active-low, one-hot when valid
//   frame_data   decoded digit values, digit i in bits [4i+3:4i]
//   frame_blank  per-digit flag, set when the digit was captured blank
//   frame_valid  high while a complete frame is presented
//   frame_ready  consumer accepts the presented frame
//   pattern_err  one-cycle pulse when a stable pattern is not decodable
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic [NUM_DIGITS-1:0]   frame_blank,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    pattern_err
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} stateT;

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  stateT                    r_state;
  stateT                    w_stateNext;
  logic [6:0]               r_seg;
  logic [NUM_DIGITS-1:0]    r_an;
  logic [6:0]               r_segPrev;
  logic [NUM_DIGITS-1:0]    r_anPrev;
  logic [7:0]               r_count;
  logic [4*NUM_DIGITS-1:0]  r_data;
  logic [NUM_DIGITS-1:0]    r_blank;
  logic [NUM_DIGITS-1:0]    r_seen;
  logic                     r_patternErr;

  logic [3:0]               w_lowCount;
  logic                     w_anValid;
  logic                     w_changed;
  logic [7:0]               w_countNext;
  logic                     w_accept;
  logic [5:0]               w_dec;
  logic                     w_decValid;
  logic                     w_decBlank;
  logic [3:0]               w_decValue;

  // Decode result is {valid, blank, value}; anything not listed is invalid.
  function automatic logic [5:0] decodeSeg(input logic [6:0] pat);
    case (pat)
      7'b1000000: return {2'b10, 4'd0};
      7'b1111001: return {2'b10, 4'd1};
      7'b0100100: return {2'b10, 4'd2};
      7'b0110000: return {2'b10, 4'd3};
      7'b0011001: return {2'b10, 4'd4};
      7'b0010010: return {2'b10, 4'd5};
      7'b0000010: return {2'b10, 4'd6};
      7'b1111000: return {2'b10, 4'd7};
      7'b0000000: return {2'b10, 4'd8};
      7'b0010000: return {2'b10, 4'd9};
      7'b1111111: return {2'b11, 4'd0};
`ifdef SEG_DECODE_HEX_EN
      7'b0001000: return {2'b10, 4'd10};
      7'b0000011: return {2'b10, 4'd11};
      7'b1000110: return {2'b10, 4'd12};
      7'b0100001: return {2'b10, 4'd13};
      7'b0000110: return {2'b10, 4'd14};
      7'b0001110: return {2'b10, 4'd15};
`endif
      default:    return 6'b000000;
    endcase
  endfunction

  // A sample only counts when exactly one anode is driven low.
  always_comb begin
    w_lowCount = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_lowCount = w_lowCount + {3'b000, ~r_an[i]};
    end
    w_anValid = (w_lowCount == 4'd1);
  end

  // Stability counter: restarts at 1 on any change, saturates at the
  // threshold, and is held at 0 by an invalid anode sample. The change term
  // in the accept condition covers a threshold of 1, where the counter sits
  // at the threshold both before and after a change.
  always_comb begin
    w_changed   = ({r_seg, r_an} != {r_segPrev, r_anPrev});
    w_countNext = r_count;
    if (!w_anValid) begin
      w_countNext = 8'd0;
    end else if (w_changed) begin
      w_countNext = 8'd1;
    end else if (r_count != STABLE_MAX) begin
      w_countNext = r_count + 8'd1;
    end
    w_accept = w_anValid && (w_countNext == STABLE_MAX) &&
               (w_changed || (r_count != STABLE_MAX));
  end

  assign w_dec      = decodeSeg(r_seg);
  assign w_decValid = w_dec[5];
  assign w_decBlank = w_dec[4];
  assign w_decValue = w_dec[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // The frame is declared complete one cycle after the last seen bit lands.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      COLLECT: if (&r_seen) w_stateNext = HOLD;
      HOLD:    if (frame_ready) w_stateNext = COLLECT;
      default: w_stateNext = COLLECT;
    endcase
  end

  // Slot contents survive a frame handoff; only the seen bits are cleared,
  // so each new frame needs every digit again but keeps old values visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg        <= '1;
      r_an         <= '1;
      r_segPrev    <= '1;
      r_anPrev     <= '1;
      r_count      <= 8'd0;
      r_data       <= '0;
      r_blank      <= '0;
      r_seen       <= '0;
      r_patternErr <= 1'b0;
    end else begin
      r_seg        <= seg_in;
      r_an         <= an_in;
      r_segPrev    <= r_seg;
      r_anPrev     <= r_an;
      r_count      <= w_countNext;
      r_patternErr <= w_accept && !w_decValid;
      if ((r_state == HOLD) && frame_ready) begin
        r_seen <= '0;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_accept && w_decValid && (r_state == COLLECT) && !r_an[i]) begin
          r_data[4*i +: 4] <= w_decValue;
          r_blank[i]       <= w_decBlank;
          r_seen[i]        <= 1'b1;
        end
      end
    end
  end

  assign frame_data  = r_data;
  assign frame_blank = r_blank;
  assign frame_valid = (r_state == HOLD);
  assign pattern_err = r_patternErr;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
// Self-checking bench for seg_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
// A behavioural model keeps the history of registered samples and derives
// acceptance from run lengths of identical valid samples; directed scenarios
// are followed by randomized scanning with occasional resets.
// Honours SEG_DECODE_HEX_EN the same way the design does.
module tb_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg_in;
  logic [ND-1:0] an_in;
  logic          frame_ready;
  logic [4*ND-1:0] frame_data;
  logic [ND-1:0] frame_blank;
  logic          frame_valid;
  logic          pattern_err;

  always #5 clk = ~clk;

  seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .frame_data  (frame_data),
    .frame_blank (frame_blank),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .pattern_err (pattern_err)
  );

  int checkCount = 0;
  int failCount  = 0;

  // Observation counters used by the directed scenarios.
  int errPulses   = 0;
  int validCycles = 0;
  logic [15:0] lastValidData = '0;

  // Reference model state.
  logic [3:0]  mSlot [ND];
  bit          mBlank[ND];
  bit          mSeen [ND];
  bit          mHold;
  bit          mErr;
  logic [6:0]  mStageSeg;
  logic [ND-1:0] mStageAn;
  logic [6+ND:0] hist[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [6:0] patOf(input int v);
    case (v)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      15: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  // Returns 0..15 for a digit, 16 for blank, -1 for an undecodable pattern.
  function automatic int decodeModel(input logic [6:0] p);
    int maxV;
    maxV = 9;
`ifdef SEG_DECODE_HEX_EN
    maxV = 15;
`endif
    if (p == 7'b1111111) return 16;
    for (int v = 0; v <= maxV; v++) begin
      if (patOf(v) == p) return v;
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ND; i++) begin
      mSlot[i]  = 4'd0;
      mBlank[i] = 1'b0;
      mSeen[i]  = 1'b0;
    end
    mHold     = 1'b0;
    mErr      = 1'b0;
    mStageSeg = '1;
    mStageAn  = '1;
    hist.delete();
  endtask

  // One rising edge of the reference: the sample held in the input stage is
  // judged against the run of identical samples before it.
  task automatic modelEdge(input logic [6:0] s, input logic [ND-1:0] a,
                           input logic rdy, input logic r);
    logic [6+ND:0] cur;
    int  run;
    bit  curValid;
    bit  accept;
    bit  allSeen;
    int  dec;
    int  idx;
    if (r) begin
      modelReset();
      return;
    end
    cur = {mStageSeg, mStageAn};
    hist.push_back(cur);
    if (hist.size() > 64) void'(hist.pop_front());
    run = 0;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (hist[k] != cur || run > SC) break;
      run++;
    end
    curValid = ($countones(~mStageAn) == 1);
    accept   = curValid && (run == SC);
    allSeen  = 1'b1;
    idx      = 0;
    for (int i = 0; i < ND; i++) begin
      if (!mSeen[i]) allSeen = 1'b0;
      if (!mStageAn[i]) idx = i;
    end
    dec  = decodeModel(mStageSeg);
    mErr = accept && (dec < 0);
    if (!mHold) begin
      if (accept && dec >= 0) begin
        mSlot[idx]  = (dec == 16) ? 4'd0 : 4'(dec);
        mBlank[idx] = (dec == 16);
        mSeen[idx]  = 1'b1;
      end
      if (allSeen) mHold = 1'b1;
    end else if (rdy) begin
      mHold = 1'b0;
      for (int i = 0; i < ND; i++) mSeen[i] = 1'b0;
    end
    mStageSeg = s;
    mStageAn  = a;
  endtask

  // Drive one cycle, advance the model past the edge, then compare every
  // output against it a little after the edge.
  task automatic applyStimulus(input logic [6:0] s, input logic [ND-1:0] a,
                               input logic rdy, input logic r);
    logic [15:0] expData;
    logic [ND-1:0] expBlank;
    seg_in      = s;
    an_in       = a;
    frame_ready = rdy;
    rst         = r;
    @(posedge clk);
    modelEdge(s, a, rdy, r);
    #1;
    for (int i = 0; i < ND; i++) begin
      expData[4*i +: 4] = mSlot[i];
      expBlank[i]       = mBlank[i];
    end
    checkOutput("frame_data",  32'(frame_data),  32'(expData));
    checkOutput("frame_blank", 32'(frame_blank), 32'(expBlank));
    checkOutput("frame_valid", 32'(frame_valid), 32'(mHold));
    checkOutput("pattern_err", 32'(pattern_err), 32'(mErr));
    if (pattern_err === 1'b1) errPulses++;
    if (frame_valid === 1'b1) begin
      validCycles++;
      lastValidData = frame_data;
    end
  endtask

  task automatic scanDigit(input int v, input int pos, input int cycles, input logic rdy);
    logic [ND-1:0] oneHot;
    oneHot = ND'(1) << pos;
    for (int c = 0; c < cycles; c++) applyStimulus(patOf(v), ~oneHot, rdy, 1'b0);
  endtask

  task automatic idle(input int cycles, input logic rdy);
    for (int c = 0; c < cycles; c++) applyStimulus(7'b1111111, '1, rdy, 1'b0);
  endtask

  initial begin
    logic [6:0] rs;
    logic [ND-1:0] ra;
    logic [ND-1:0] oneHot;
    int kind;
    int hold;

    modelReset();

    // Reset held for two cycles with arbitrary inputs.
    for (int c = 0; c < 2; c++) applyStimulus(7'($urandom), ND'($urandom), 1'($urandom), 1'b1);
    checkOutput("reset_data",  32'(frame_data),  32'h0);
    checkOutput("reset_blank", 32'(frame_blank), 32'h0);
    checkOutput("reset_valid", 32'(frame_valid), 32'h0);
    checkOutput("reset_err",   32'(pattern_err), 32'h0);

    // Basic scan of 0,1,2,3 with the consumer always ready.
    validCycles = 0;
    for (int d = 0; d < ND; d++) scanDigit(d, d, 8, 1'b1);
    idle(4, 1'b1);
    checkOutput("scan_valid_cycles", 32'(validCycles), 32'd1);
    checkOutput("scan_data", 32'(lastValidData), 32'h3210);

    // Three-cycle glitch of a '2' on digit 0 is too short to be taken.
    scanDigit(2, 0, 3, 1'b1);
    idle(4, 1'b1);
    checkOutput("glitch_slot0", 32'(frame_data[3:0]), 32'h0);

    // Hex 'A' on digit 1.
    errPulses = 0;
    scanDigit(10, 1, 8, 1'b1);
    idle(4, 1'b1);
`ifdef SEG_DECODE_HEX_EN
    checkOutput("hex_err_pulses", 32'(errPulses), 32'd0);
    checkOutput("hex_slot1", 32'(frame_data[7:4]), 32'hA);
`else
    checkOutput("hex_err_pulses", 32'(errPulses), 32'd1);
    checkOutput("hex_slot1", 32'(frame_data[7:4]), 32'h1);
`endif

    // Consumer stalls: a completed frame must stay put while new digits scan.
    for (int d = 0; d < ND; d++) scanDigit(4 + d, d, 8, 1'b0);
    for (int c = 0; c < 6; c++) scanDigit(8 + (c % 2), c % ND, 4, 1'b0);
    checkOutput("stall_data",  32'(frame_data),  32'h7654);
    checkOutput("stall_valid", 32'(frame_valid), 32'd1);
    applyStimulus(7'b1111111, '1, 1'b1, 1'b0);
    checkOutput("release_valid", 32'(frame_valid), 32'd0);

    // Two anodes low at once is never a digit.
    errPulses = 0;
    for (int c = 0; c < 10; c++) applyStimulus(patOf(5), 4'b1100, 1'b1, 1'b0);
    idle(3, 1'b1);
    checkOutput("multi_anode_err", 32'(errPulses), 32'd0);
    checkOutput("multi_anode_valid", 32'(frame_valid), 32'd0);

    // Randomized scanning, consumer back-pressure and occasional resets.
    for (int seg = 0; seg < 500; seg++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5)      rs = patOf($urandom_range(0, 9));
      else if (kind == 6) rs = 7'b1111111;
      else if (kind == 7) rs = patOf($urandom_range(10, 15));
      else                rs = 7'($urandom);
      oneHot = ND'(1) << $urandom_range(0, ND - 1);
      ra     = ($urandom_range(0, 9) < 8) ? ~oneHot : ND'($urandom);
      hold   = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        applyStimulus(rs, ra, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
